// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one req/ack memory between instruction-fetch and data ports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_ctrl,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [2:0]    m_ctrl,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_data;
    logic [15:0] r_wd_cnt;
    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_wd_hit;

    // A port whose valid is pulsing this cycle is already served.
    assign w_i_pend = i_req & ~i_valid;
    assign w_d_pend = d_req & ~d_valid;
    assign stall    = w_i_pend | w_d_pend;
    assign w_wd_hit = (r_wd_cnt >= (C_TIMEOUT - 16'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_pend && (!w_d_pend || r_last_data)) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_d_pend) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_FETCH, S_DATA: begin
                if (m_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_ctrl      <= 3'd0;
            m_addr      <= '0;
            m_wdata     <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_valid     <= 1'b0;
            d_valid     <= 1'b0;
            err         <= 1'b0;
            r_last_data <= 1'b1;
            r_wd_cnt    <= 16'd0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (w_grant_i) begin
                m_req    <= 1'b1;
                m_we     <= 1'b0;
                m_ctrl   <= 3'd0;
                m_addr   <= i_addr;
                m_wdata  <= '0;
                r_wd_cnt <= 16'd0;
            end else if (w_grant_d) begin
                m_req    <= 1'b1;
                m_we     <= d_we;
                m_ctrl   <= d_ctrl;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                r_wd_cnt <= 16'd0;
            end else if (r_state != S_IDLE) begin
                if (m_ack) begin
                    m_req <= 1'b0;
                    m_we  <= 1'b0;
                    if (r_state == S_FETCH) begin
                        i_rdata     <= m_rdata;
                        i_valid     <= 1'b1;
                        r_last_data <= 1'b0;
                    end else begin
                        // Stores complete with a pulse but leave load data intact.
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        d_valid     <= 1'b1;
                        r_last_data <= 1'b1;
                    end
                end else if (m_req) begin
                    if (r_wd_cnt != 16'hFFFF) begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                    if (w_wd_hit) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
